restoring_divider: RTL and testbench

RESTORING_DIVIDER -- requirements
Module: restoring_divider

---
 rtl/restoring_divider_pkg.sv | 14 +
 rtl/div_addsub.sv | 18 +
 rtl/restoring_divider.sv | 123 ++++++++++++
 tb/tb_restoring_divider.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/restoring_divider_pkg.sv
// Shared definitions for the restoring divider.
//   DEFAULT_WIDTH : default operand/result width
//   state_t       : controller states (IDLE, RUN, DONE)
package restoring_divider_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_addsub.sv
// Combinational add/subtract used by the divider datapath.
//   a, b : WIDTH-bit operands
//   sub  : 1 selects a - b, 0 selects a + b
//   y    : WIDTH-bit result, modulo 2^WIDTH
module div_addsub #(
    parameter int unsigned WIDTH = 5
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = sub ? (a - b) : (a + b);
    end

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
//   clk, reset            : rising-edge clock, asynchronous active-low reset
//   start                 : request, sampled only in IDLE
//   dividend, divisor     : operands, captured when start is accepted
//   quotient, remainder   : result, held until overwritten by the next result
//   busy                  : high while iterating
//   done                  : one-cycle pulse while the result is first valid
//   div_by_zero           : set with done when the captured divisor was 0
//   count                 : iteration index during RUN
module restoring_divider
    import restoring_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [CW-1:0]    count
);

    state_t             state;
    logic [WIDTH:0]     a_reg;      // partial remainder, sign in bit WIDTH
    logic [WIDTH-1:0]   q_reg;
    logic [WIDTH-1:0]   m_reg;

    logic [2*WIDTH:0]   aq_sh;
    logic [WIDTH:0]     a_sh;
    logic [WIDTH-1:0]   q_sh;
    logic [WIDTH:0]     diff;
    logic               neg;
    logic [WIDTH:0]     a_next;
    logic [WIDTH-1:0]   q_next;
    logic               last_iter;

    div_addsub #(
        .WIDTH(WIDTH + 1)
    ) u_addsub (
        .a   (a_sh),
        .b   ({1'b0, m_reg}),
        .sub (1'b1),
        .y   (diff)
    );

    // Restoring A-M+M modulo 2^(WIDTH+1) yields the pre-subtraction value,
    // so the restore step selects the shifted A instead of a second adder.
    always_comb begin
        aq_sh     = {a_reg, q_reg} << 1;
        a_sh      = aq_sh[2*WIDTH:WIDTH];
        q_sh      = aq_sh[WIDTH-1:0];
        neg       = diff[WIDTH];
        a_next    = neg ? a_sh : diff;
        q_next    = q_sh | {{(WIDTH-1){1'b0}}, ~neg};
        last_iter = (count == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            a_reg       <= '0;
            q_reg       <= '0;
            m_reg       <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        m_reg <= divisor;
                        q_reg <= dividend;
                        a_reg <= '0;
                        count <= '0;
                        if (divisor == '0) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            div_by_zero <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                        end else begin
                            state       <= RUN;
                            busy        <= 1'b1;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    a_reg <= a_next;
                    q_reg <= q_next;
                    count <= count + CW'(1);
                    if (last_iter) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= q_next;
                        remainder <= a_next[WIDTH-1:0];
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider (WIDTH=4): directed vector table,
// multi-cycle corner sequences, exhaustive and random operand sweeps against
// a plain-arithmetic reference model.
module tb_restoring_divider;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CW    = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [CW-1:0]    count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic [3:0] r;
        logic       z;
    } vec_t;

    always #5 clk = ~clk;

    restoring_divider #(
        .WIDTH(WIDTH),
        .CW   (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero),
        .count      (count)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: integer division; divide-by-zero gives all-ones / dividend.
    function automatic void model(input int a, input int b,
                                  output int q, output int r, output int z,
                                  output int lat, output int bc);
        if (b == 0) begin
            q = 15; r = a; z = 1; lat = 1; bc = 0;
        end else begin
            q = a / b; r = a % b; z = 0; lat = WIDTH + 1; bc = WIDTH;
        end
    endfunction

    // Called at a negedge while the DUT is idle; returns at a negedge in IDLE.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          output int lat, output int bc,
                          output int q, output int r, output int z,
                          output int pw);
        lat = 0; bc = 0; q = -1; r = -1; z = -1; pw = -1;
        start = 1'b1; dividend = a; divisor = b;
        while (lat < 20) begin
            @(negedge clk);
            if (lat == 0) begin
                start    = 1'b0;
                dividend = 4'($urandom);
                divisor  = 4'($urandom);
            end
            lat++;
            if (busy) bc++;
            if (done) begin
                q = int'(quotient); r = int'(remainder); z = int'(div_by_zero);
                break;
            end
        end
        @(negedge clk);
        pw = int'(done);
    endtask

    task automatic check_op(input logic [3:0] a, input logic [3:0] b);
        int lat, bc, q, r, z, pw;
        int eq, er, ez, elat, ebc;
        run_op(a, b, lat, bc, q, r, z, pw);
        model(int'(a), int'(b), eq, er, ez, elat, ebc);
        check($sformatf("quotient %0d/%0d", a, b), q, eq);
        check($sformatf("remainder %0d/%0d", a, b), r, er);
        check($sformatf("div_by_zero %0d/%0d", a, b), z, ez);
        check($sformatf("latency %0d/%0d", a, b), lat, elat);
        check($sformatf("busy_cycles %0d/%0d", a, b), bc, ebc);
        check($sformatf("done_width %0d/%0d", a, b), pw, 0);
    endtask

    initial begin
        vec_t vecs[8];
        int   dones;
        int   gq, gr;
        int   n;

        vecs[0] = '{a: 4'd13, b: 4'd3,  q: 4'd4,  r: 4'd1, z: 1'b0};
        vecs[1] = '{a: 4'd3,  b: 4'd9,  q: 4'd0,  r: 4'd3, z: 1'b0};
        vecs[2] = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0, z: 1'b0};
        vecs[3] = '{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0, z: 1'b0};
        vecs[4] = '{a: 4'd7,  b: 4'd0,  q: 4'd15, r: 4'd7, z: 1'b1};
        vecs[5] = '{a: 4'd0,  b: 4'd5,  q: 4'd0,  r: 4'd0, z: 1'b0};
        vecs[6] = '{a: 4'd8,  b: 4'd3,  q: 4'd2,  r: 4'd2, z: 1'b0};
        vecs[7] = '{a: 4'd14, b: 4'd4,  q: 4'd3,  r: 4'd2, z: 1'b0};

        reset = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        check("reset quotient", int'(quotient), 0);
        check("reset remainder", int'(remainder), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset div_by_zero", int'(div_by_zero), 0);
        check("reset count", int'(count), 0);
        reset = 1'b1;
        @(negedge clk);

        // Directed vector table.
        foreach (vecs[i]) begin
            int lat, bc, q, r, z, pw;
            run_op(vecs[i].a, vecs[i].b, lat, bc, q, r, z, pw);
            check($sformatf("vec%0d quotient", i), q, int'(vecs[i].q));
            check($sformatf("vec%0d remainder", i), r, int'(vecs[i].r));
            check($sformatf("vec%0d div_by_zero", i), z, int'(vecs[i].z));
            check($sformatf("vec%0d latency", i), lat, vecs[i].z ? 1 : WIDTH + 1);
            check($sformatf("vec%0d busy_cycles", i), bc, vecs[i].z ? 0 : WIDTH);
            check($sformatf("vec%0d done_width", i), pw, 0);
        end

        // start pulsed with 9/2 while 13/3 is running.
        dones = 0; gq = -1; gr = -1;
        start = 1'b1; dividend = 4'd13; divisor = 4'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; dividend = 4'd9; divisor = 4'd2;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (done) begin
                dones++; gq = int'(quotient); gr = int'(remainder);
            end
            @(negedge clk);
        end
        check("ignore_start done_pulses", dones, 1);
        check("ignore_start quotient", gq, 4);
        check("ignore_start remainder", gr, 1);
        check("hold quotient", int'(quotient), 4);
        check("hold remainder", int'(remainder), 1);

        // Reset dropped mid-RUN at count==2.
        start = 1'b1; dividend = 4'd13; divisor = 4'd3;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(busy && count == 2'd2) && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("midrun reached count2", n < 10 ? 1 : 0, 1);
        reset = 1'b0;
        #1;
        check("midrun reset quotient", int'(quotient), 0);
        check("midrun reset remainder", int'(remainder), 0);
        check("midrun reset busy", int'(busy), 0);
        check("midrun reset done", int'(done), 0);
        check("midrun reset div_by_zero", int'(div_by_zero), 0);
        check("midrun reset count", int'(count), 0);
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("midrun no_done", dones, 0);
        check_op(4'd8, 4'd3);

        // Exhaustive sweep, back-to-back starts.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                check_op(4'(a), 4'(b));
            end
        end

        // Random operands with random idle gaps.
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            check_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
